// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART frame sequencer driving an external data shifter
// Sequences start/data/parity/stop periods and paces the shifter with start/shift pulses.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] sh_data,
  output logic                 sh_start,
  output logic                 sh_en,
  output logic                 sh_shift,
  input  logic                 sh_bit,
  input  logic                 sh_done,
  output logic                 tx_o,
  output logic                 tx_done,
  output logic                 sh_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [BW-1:0]   bit_cnt;
  logic            par_en_q, par_odd_q, stop2_q;
  logic            chk_done;
  logic            accept, period_last, bit_last, tx_o_next;

  assign tx_ready = (state == IDLE);

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    tx_o_next   = 1'b1;
    period_last = (state != IDLE) && (cnt == CNT_LAST);
    bit_last    = (bit_cnt == BIT_LAST);
    case (state)
      IDLE:    if (tx_valid) begin
                 accept     = 1'b1;
                 state_next = START;
               end
      START:   if (period_last) state_next = DATA;
      DATA:    if (period_last && bit_last) state_next = par_en_q ? PARITY : STOP1;
      PARITY:  if (period_last) state_next = STOP1;
      STOP1:   if (period_last) state_next = stop2_q ? STOP2 : IDLE;
      STOP2:   if (period_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Counter wraps at each period end, including between consecutive data bits.
    cnt_next = (period_last || (state_next != state) || (state_next == IDLE)) ? '0 : cnt + CW'(1);
    case (state_next)
      START:   tx_o_next = 1'b0;
      DATA:    tx_o_next = sh_bit;
      PARITY:  tx_o_next = (^sh_data) ^ par_odd_q;
      default: tx_o_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh_data   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      sh_start  <= 1'b0;
      sh_en     <= 1'b1;
      sh_shift  <= 1'b0;
      tx_o      <= 1'b1;
      tx_done   <= 1'b0;
      sh_err    <= 1'b0;
      chk_done  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sh_en    <= 1'b1;
      sh_start <= accept;
      sh_shift <= (state_next == DATA) && (cnt_next == CNT_LAST);
      tx_done  <= (cnt_next == CNT_LAST) &&
                  ((state_next == STOP2) || ((state_next == STOP1) && !stop2_q));
      tx_o     <= tx_o_next;
      // The shifter updates sh_done on the final shift edge, so it is judged one cycle later.
      chk_done <= (state == DATA) && period_last && bit_last;
      if (chk_done && !sh_done) sh_err <= 1'b1;
      if (accept) begin
        sh_data   <= tx_data;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        stop2_q   <= stop2;
        bit_cnt   <= '0;
      end else if ((state == DATA) && period_last) begin
        bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with a behavioural shifter
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          tx_valid, tx_ready;
  logic [DB-1:0] tx_data, sh_data;
  logic          parity_en, parity_odd, stop2;
  logic          sh_start, sh_en, sh_shift, sh_bit, sh_done;
  logic          tx_o, tx_done, sh_err;

  logic [DB-1:0] sreg;
  logic [3:0]    scnt;
  logic          sdone;
  logic          withhold;

  typedef struct {
    logic [11:0] bits;
    int          nper;
    logic        abort;
    logic        err;
  } frame_t;

  frame_t q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  logic   mon_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .arst_n(arst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .sh_data(sh_data), .sh_start(sh_start), .sh_en(sh_en), .sh_shift(sh_shift),
    .sh_bit(sh_bit), .sh_done(sh_done), .tx_o(tx_o), .tx_done(tx_done), .sh_err(sh_err)
  );

  // LSB-first shifter; withhold suppresses its completion flag.
  always @(posedge clk) begin
    if (!arst_n) begin
      sreg <= '0; scnt <= '0; sdone <= 1'b0;
    end else if (sh_start) begin
      sreg <= sh_data; scnt <= '0; sdone <= 1'b0;
    end else if (sh_shift) begin
      sreg  <= sreg >> 1;
      scnt  <= scnt + 4'd1;
      sdone <= (scnt == 4'(DB - 1)) && !withhold;
    end
  end
  assign sh_bit  = sreg[0];
  assign sh_done = sdone;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mkf(input logic [11:0] b, input int n, input logic ab, input logic er);
    frame_t f;
    f.bits = b; f.nper = n; f.abort = ab; f.err = er;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic s2,
                      input logic hold, input frame_t exp);
    int n = 0;
    @(posedge clk); #1;
    while (!tx_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_timeout", 32'(n < 2000), 32'd1);
    tx_valid = 1'b1; tx_data = d; parity_en = pe; parity_odd = po; stop2 = s2;
    @(posedge clk);
    q.push_back(exp);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || mon_busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 5000), 32'd1);
  endtask

  // Monitor: recovers each frame at mid-period and compares against the queued expectation.
  initial begin : monitor
    frame_t      it;
    logic [11:0] got;
    int          done_cnt, done_cyc, shifts, starts, start_cyc, ready_hi;
    logic        rst;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && tx_o === 1'b0) begin
        mon_busy = 1'b1;
        check("frame_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() == 0) begin
          repeat (60) @(negedge clk);
        end else begin
          it = q.pop_front();
          got = '0; done_cnt = 0; done_cyc = 0; shifts = 0; starts = 0;
          start_cyc = 0; ready_hi = 0; rst = 1'b0;
          for (int cyc = 1; cyc <= it.nper * CPB; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (!arst_n) begin
              rst = 1'b1;
              break;
            end
            if (cyc % CPB == 3) got[(cyc - 3) / CPB] = tx_o;
            if (tx_done) begin done_cnt++; done_cyc = cyc; end
            if (sh_shift) shifts++;
            if (sh_start) begin starts++; start_cyc = cyc; end
            if (tx_ready) ready_hi++;
          end
          check("reset_abort", 32'(rst), 32'(it.abort));
          check("tx_done_cnt", 32'(done_cnt), it.abort ? 32'd0 : 32'd1);
          if (!rst) begin
            check("frame_bits", 32'(got), 32'(it.bits));
            check("tx_done_cycle", 32'(done_cyc), 32'(it.nper * CPB));
            check("sh_shift_cnt", 32'(shifts), 32'(DB));
            check("sh_start_cnt", 32'(starts), 32'd1);
            check("sh_start_cycle", 32'(start_cyc), 32'd1);
            check("busy_ready", 32'(ready_hi), 32'd0);
            @(negedge clk);
            check("gap_ready", 32'(tx_ready), 32'd1);
            check("gap_line", 32'(tx_o), 32'd1);
            check("sh_err", 32'(sh_err), 32'(it.err));
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    int n_done, n_shift;
    arst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; withhold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_o", 32'(tx_o), 32'd1);
    check("rst_sh_en", 32'(sh_en), 32'd1);
    check("rst_sh_start", 32'(sh_start), 32'd0);
    check("rst_sh_shift", 32'(sh_shift), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_sh_err", 32'(sh_err), 32'd0);
    check("rst_sh_data", 32'(sh_data), 32'd0);
    @(posedge clk); #1 arst_n = 1'b1;

    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, mkf(12'b0011_0100_1010, 10, 1'b0, 1'b0));
    drain();

    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, mkf(12'b1110_0000_1110, 12, 1'b0, 1'b0));
    drain();
    send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, mkf(12'b1100_0000_1110, 12, 1'b0, 1'b0));
    drain();

    for (int k = 0; k < 3; k++)
      send(8'h3C, 1'b0, 1'b0, 1'b0, (k < 2), mkf(12'b0010_0111_1000, 10, 1'b0, 1'b0));
    drain();

    send(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, mkf(12'b0111_0010_1100, 11, 1'b0, 1'b0));
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      tx_data = ~tx_data; parity_en = ~parity_en; parity_odd = ~parity_odd; stop2 = ~stop2;
    end
    drain();

    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, mkf(12'b0, 10, 1'b1, 1'b0));
    repeat (18) @(posedge clk);
    #1 arst_n = 1'b0;
    @(posedge clk); #1 arst_n = 1'b1;
    @(negedge clk);
    check("abort_tx_ready", 32'(tx_ready), 32'd1);
    check("abort_tx_o", 32'(tx_o), 32'd1);
    check("abort_sh_err", 32'(sh_err), 32'd0);
    n_done = 0; n_shift = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_done) n_done++;
      if (sh_shift) n_shift++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_no_shift", 32'(n_shift), 32'd0);
    drain();

    withhold = 1'b1;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, mkf(12'b0011_0100_1010, 10, 1'b0, 1'b1));
    drain();
    withhold = 1'b0;
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, mkf(12'b0010_0111_1000, 10, 1'b0, 1'b1));
    drain();
    @(posedge clk); #1 arst_n = 1'b0;
    @(posedge clk); #1 arst_n = 1'b1;
    @(negedge clk);
    check("err_cleared", 32'(sh_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
